instr_mem_loader: RTL and testbench

Byte-stream program loader that sits directly upstream of the read/write instruction memory in the programming device. It consumes bytes from the UART receiver, parses a framed download (sync byte, start address, word count, payload), and issues single-word writes on the instruction memory write port. While a download is in progress it holds the processor core in reset.

---
 rtl/loader_pkg.sv | 20 ++
 rtl/byte_assembler.sv | 38 +++
 rtl/instr_mem_loader.sv | 152 +++++++++++++++
 tb/tb_instr_mem_loader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | loader_pkg : shared state encoding and framing constants for the loader   |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    COUNT = 3'd2,
    DATA  = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/byte_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | byte_assembler : little-endian 4-byte word builder with byte counter      |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
module byte_assembler (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  input  logic        clear_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [23:0] shift_q;
  logic [1:0]  cnt_q;

  // Word and strobe are presented in the same cycle as the 4th byte so the
  // consumer can register the result on the edge that samples that byte.
  assign word_o       = {byte_i, shift_q};
  assign word_valid_o = byte_valid_i && (cnt_q == 2'd3);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clear_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (byte_valid_i) begin
      shift_q <= {byte_i, shift_q[23:8]};
      cnt_q   <= cnt_q + 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_mem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_mem_loader : framed UART byte-stream loader for instruction memory  |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int unsigned MEM_SIZE_BYTES = 65536,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic [31:0] write_addr_o,
  output logic [31:0] write_data_o,
  output logic        write_enable_o,
  output logic        core_reset_o,
  output logic        done_o,
  output logic        error_o
);

  localparam int unsigned      IDLE_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] TIMEOUT_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [34:0]      MEM_LIMIT    = 35'(MEM_SIZE_BYTES);

  state_e             state_q, state_d;
  logic [31:0]        start_addr_q, start_addr_d;
  logic [31:0]        count_q, count_d;
  logic [31:0]        k_q, k_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic [31:0]        wr_addr_q, wr_addr_d;
  logic [31:0]        wr_data_q, wr_data_d;
  logic               we_q, we_d;
  logic               core_reset_q, done_q, error_q;

  logic        w_active;
  logic        w_finished;
  logic        w_asm_valid;
  logic        w_asm_clear;
  logic [31:0] w_word;
  logic        w_word_valid;
  logic [34:0] w_end;

  assign w_active    = (state_q == ADDR) || (state_q == COUNT) || (state_q == DATA);
  assign w_finished  = (state_q == DATA) && (k_q == count_q);
  assign w_asm_valid = rx_valid_i && w_active;
  assign w_asm_clear = (state_d != state_q);
  // 35 bits so address plus byte length can never wrap below the limit.
  assign w_end       = {3'b000, start_addr_q} + {1'b0, w_word, 2'b00};

  byte_assembler u_asm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .byte_valid_i (w_asm_valid),
    .byte_i       (rx_data_i),
    .clear_i      (w_asm_clear),
    .word_o       (w_word),
    .word_valid_o (w_word_valid)
  );

  always_comb begin
    state_d      = state_q;
    start_addr_d = start_addr_q;
    count_d      = count_q;
    k_d          = k_q;
    idle_d       = '0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    we_d         = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_valid_i && (rx_data_i == SYNC_BYTE)) state_d = ADDR;
      end
      ADDR: begin
        if (w_word_valid) begin
          start_addr_d = w_word;
          state_d      = COUNT;
        end
      end
      COUNT: begin
        if (w_word_valid) begin
          count_d = w_word;
          k_d     = '0;
          if (start_addr_q[1:0] != 2'b00) state_d = ERR;
          else if (w_end > MEM_LIMIT)     state_d = ERR;
          else if (w_word == '0)          state_d = DONE;
          else                            state_d = DATA;
        end
      end
      DATA: begin
        // The final write gets its own cycle so done follows it by one cycle.
        if (w_finished) begin
          state_d = DONE;
        end else if (w_word_valid) begin
          we_d      = 1'b1;
          wr_addr_d = start_addr_q + (k_q << 2);
          wr_data_d = w_word;
          k_d       = k_q + 32'd1;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (w_active && !w_finished) begin
      if (rx_valid_i)                  idle_d = '0;
      else if (idle_q == TIMEOUT_LAST) state_d = ERR;
      else                             idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      start_addr_q <= '0;
      count_q      <= '0;
      k_q          <= '0;
      idle_q       <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      we_q         <= 1'b0;
      core_reset_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_addr_q <= start_addr_d;
      count_q      <= count_d;
      k_q          <= k_d;
      idle_q       <= idle_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      we_q         <= we_d;
      core_reset_q <= (state_d == ADDR) || (state_d == COUNT) || (state_d == DATA);
      done_q       <= (state_d == DONE);
      error_q      <= (state_d == ERR);
    end
  end

  assign write_addr_o   = wr_addr_q;
  assign write_data_o   = wr_data_q;
  assign write_enable_o = we_q;
  assign core_reset_o   = core_reset_q;
  assign done_o         = done_q;
  assign error_o        = error_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_instr_mem_loader : directed self-checking bench for instr_mem_loader   |
// | Revision            : 1.0                                                  |
// +----------------------------------------------------------------------------+
module tb_instr_mem_loader;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        rx_valid_i = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic [31:0] write_addr_o;
  logic [31:0] write_data_o;
  logic        write_enable_o;
  logic        core_reset_o;
  logic        done_o;
  logic        error_o;

  instr_mem_loader #(
    .MEM_SIZE_BYTES (65536),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .rx_valid_i     (rx_valid_i),
    .rx_data_i      (rx_data_i),
    .write_addr_o   (write_addr_o),
    .write_data_o   (write_data_o),
    .write_enable_o (write_enable_o),
    .core_reset_o   (core_reset_o),
    .done_o         (done_o),
    .error_o        (error_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int          wcyc[$];
  int          done_cnt = 0;
  int          err_cnt  = 0;
  int          done_cyc = -1;
  int          err_cyc  = -1;
  int          t0;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (write_enable_o) begin
      wa.push_back(write_addr_o);
      wd.push_back(write_data_o);
      wcyc.push_back(cyc);
    end
    if (done_o)  begin done_cnt++; done_cyc = cyc; end
    if (error_o) begin err_cnt++;  err_cyc  = cyc; end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wa.delete(); wd.delete(); wcyc.delete();
    done_cnt = 0; err_cnt = 0; done_cyc = -1; err_cyc = -1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    @(posedge clk_i);
    #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic send_hdr(input logic [31:0] addr, input logic [31:0] n);
    send_byte(8'hA5);
    send_word(addr);
    send_word(n);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  initial begin
    // Reset state
    idle(3);
    check("reset_ctrl", {write_enable_o, core_reset_o, done_o, error_o}, 4'b0000);
    check("reset_addr", write_addr_o, 32'h0);
    check("reset_data", write_data_o, 32'h0);
    rst_i = 1'b0;
    idle(2);

    // Two-word frame, bytes back-to-back
    clear_mon();
    send_byte(8'hA5);
    check("a_core_reset_after_sync", core_reset_o, 1'b1);
    send_word(32'h0000_0010);
    send_word(32'h0000_0002);
    send_word(32'h1122_3344);
    send_word(32'hAABB_CCDD);
    check("a_core_reset_last_write", core_reset_o, 1'b1);
    check("a_we_after_last_byte", write_enable_o, 1'b1);
    idle(4);
    check("a_nwrites", wa.size(), 2);
    check("a_addr0", wa[0], 32'h10);
    check("a_data0", wd[0], 32'h1122_3344);
    check("a_addr1", wa[1], 32'h14);
    check("a_data1", wd[1], 32'hAABB_CCDD);
    check("a_done_cnt", done_cnt, 1);
    check("a_done_latency", done_cyc, wcyc[1] + 1);
    check("a_back_to_back_writes", wcyc[1] - wcyc[0], 4);
    check("a_err_cnt", err_cnt, 0);
    check("a_core_reset_end", core_reset_o, 1'b0);

    // Garbage before sync, then empty frame
    clear_mon();
    send_byte(8'h00);
    send_byte(8'hFF);
    check("g_no_core_reset", core_reset_o, 1'b0);
    send_hdr(32'h0, 32'h0);
    idle(3);
    check("g_nwrites", wa.size(), 0);
    check("g_done_cnt", done_cnt, 1);
    check("g_err_cnt", err_cnt, 0);

    // Range overflow by one word
    clear_mon();
    send_hdr(32'h0000_FFFC, 32'h2);
    t0 = cyc;
    idle(3);
    check("r_err_cnt", err_cnt, 1);
    check("r_err_cycle", err_cyc, t0);
    check("r_nwrites", wa.size(), 0);
    check("r_done_cnt", done_cnt, 0);

    // Exactly fills memory to the top
    clear_mon();
    send_hdr(32'h0000_FFF8, 32'h2);
    send_word(32'h0BAD_F00D);
    send_word(32'h1234_5678);
    idle(3);
    check("top_nwrites", wa.size(), 2);
    check("top_addr1", wa[1], 32'h0000_FFFC);
    check("top_done_cnt", done_cnt, 1);
    check("top_err_cnt", err_cnt, 0);

    // Misaligned start address
    clear_mon();
    send_hdr(32'h0000_0002, 32'h1);
    idle(3);
    check("m_err_cnt", err_cnt, 1);
    check("m_nwrites", wa.size(), 0);

    // Huge counts must not wrap through the range check
    clear_mon();
    send_hdr(32'h0, 32'hFFFF_FFFF);
    idle(3);
    check("w1_err_cnt", err_cnt, 1);
    clear_mon();
    send_hdr(32'h4, 32'h3FFF_FFFF);
    idle(3);
    check("w2_err_cnt", err_cnt, 1);
    check("w2_done_cnt", done_cnt, 0);

    // Timeout after one of three words
    clear_mon();
    send_hdr(32'h0000_0100, 32'h3);
    send_word(32'hDEAD_BEEF);
    t0 = cyc;
    idle(30);
    check("t_nwrites", wa.size(), 1);
    check("t_addr0", wa[0], 32'h100);
    check("t_err_cnt", err_cnt, 1);
    check("t_err_cycle", err_cyc, t0 + 16);
    check("t_core_reset_end", core_reset_o, 1'b0);

    // Byte arriving on the 16th idle cycle wins over the timeout
    clear_mon();
    send_byte(8'hA5);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    idle(15);
    send_byte(8'h00);
    send_word(32'h0);
    idle(3);
    check("tb_err_cnt", err_cnt, 0);
    check("tb_done_cnt", done_cnt, 1);

    // Reset mid-DATA, then a fresh frame
    clear_mon();
    send_hdr(32'h0000_0200, 32'h2);
    send_word(32'h5555_AAAA);
    send_byte(8'h01);
    send_byte(8'h02);
    check("rst_core_reset_before", core_reset_o, 1'b1);
    #2;
    rst_i = 1'b1;
    #1;
    check("rst_ctrl_async", {write_enable_o, core_reset_o, done_o, error_o}, 4'b0000);
    check("rst_addr_async", write_addr_o, 32'h0);
    check("rst_data_async", write_data_o, 32'h0);
    idle(2);
    rst_i = 1'b0;
    idle(1);
    clear_mon();
    send_hdr(32'h0000_0020, 32'h1);
    send_word(32'hCAFE_F00D);
    idle(3);
    check("rr_nwrites", wa.size(), 1);
    check("rr_addr0", wa[0], 32'h20);
    check("rr_data0", wd[0], 32'hCAFE_F00D);
    check("rr_done_cnt", done_cnt, 1);
    check("rr_err_cnt", err_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
